ws2812b_bar_driver: RTL and testbench

//  Parametrised WS2812B strip driver for level-meter bars. Streams max_count 24-bit

---
 rtl/ws2812b_bar_driver_if.sv | 33 +++
 rtl/ws2812b_bar_driver.sv | 184 ++++++++++++++++++
 tb/tb_ws2812b_bar_driver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_bar_driver_if.sv
// Meter-side bundle for the WS2812B bar driver: frame control, bar
// configuration and the serial/status outputs.
`timescale 1ns/1ps
interface ws2812b_bar_driver_if #(
  parameter int SEG_N = 4,
  parameter int CNT_W = 16
);
  logic                   enable;
  logic                   start;
  logic                   auto_mode;
  logic [SEG_N*24-1:0]    seg_colors;
  logic [SEG_N*CNT_W-1:0] seg_limits;
  logic [CNT_W-1:0]       on_count;
  logic [CNT_W-1:0]       max_count;
  logic                   peak_en;
  logic [CNT_W-1:0]       peak_pos;
  logic [23:0]            peak_color;
  logic                   dout;
  logic                   busy;
  logic                   done;

  modport master (
    output enable, start, auto_mode, seg_colors, seg_limits, on_count,
           max_count, peak_en, peak_pos, peak_color,
    input  dout, busy, done
  );

  modport slave (
    input  enable, start, auto_mode, seg_colors, seg_limits, on_count,
           max_count, peak_en, peak_pos, peak_color,
    output dout, busy, done
  );
endinterface

// File: rtl/ws2812b_bar_driver.sv
// WS2812B level-meter bar driver. Streams max_count GRB words, MSB first,
// after a latch (reset) low period. Configuration is frozen at the end of
// the latch period; the colour of the next LED is precomputed one LED ahead.
// Outputs are registered and follow the FSM state by one cycle.
`timescale 1ns/1ps
module ws2812b_bar_driver #(
  parameter int CLK_PERIOD_NS = 10,
  parameter int SEG_N         = 4,
  parameter int CNT_W         = 16,
  parameter int T0H_NS        = 400,
  parameter int T0L_NS        = 850,
  parameter int T1H_NS        = 800,
  parameter int T1L_NS        = 450,
  parameter int RESET_NS      = 100000
) (
  input  logic               clk,
  input  logic               reset,
  ws2812b_bar_driver_if.slave bus
);

  function automatic int to_cyc(input int ns);
    return (ns / CLK_PERIOD_NS < 1) ? 1 : ns / CLK_PERIOD_NS;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T0H_CYC   = to_cyc(T0H_NS);
  localparam int T0L_CYC   = to_cyc(T0L_NS);
  localparam int T1H_CYC   = to_cyc(T1H_NS);
  localparam int T1L_CYC   = to_cyc(T1L_NS);
  localparam int RESET_CYC = to_cyc(RESET_NS);
  localparam int MAX_CYC   = max2(max2(RESET_CYC, max2(T0H_CYC, T0L_CYC)),
                                  max2(T1H_CYC, T1L_CYC));
  localparam int PH_W      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;

  state_t                 state, state_next;
  logic [1:0]             rst_sync;
  logic                   rst_int;
  logic [PH_W-1:0]        phase;
  logic [4:0]             bit_cnt;
  logic [CNT_W-1:0]       led_idx;
  logic [23:0]            shift;
  logic [23:0]            next_color;
  logic [23:0]            first_color;
  logic                   dout_q, busy_q, done_q;
  logic                   phase_end, last_bit, last_led;

  logic [SEG_N*24-1:0]    cfg_colors;
  logic [SEG_N*CNT_W-1:0] cfg_limits;
  logic [CNT_W-1:0]       cfg_on, cfg_max, cfg_pos;
  logic                   cfg_pk_en;
  logic [23:0]            cfg_pk_col;

  // Peak marker wins; otherwise lit LEDs take the first segment whose limit exceeds the index.
  function automatic logic [23:0] led_color(
    input logic [CNT_W-1:0]       idx,
    input logic [SEG_N*24-1:0]    colors,
    input logic [SEG_N*CNT_W-1:0] limits,
    input logic [CNT_W-1:0]       on_cnt,
    input logic                   pk_en,
    input logic [CNT_W-1:0]       pk_pos,
    input logic [23:0]            pk_col
  );
    logic [23:0] c;
    logic        hit;
    c   = '0;
    hit = 1'b0;
    if (pk_en && idx == pk_pos) begin
      c = pk_col;
    end else if (idx < on_cnt) begin
      for (int k = 0; k < SEG_N; k++) begin
        if (!hit && idx < limits[k*CNT_W +: CNT_W]) begin
          c   = colors[k*24 +: 24];
          hit = 1'b1;
        end
      end
    end
    return c;
  endfunction

  function automatic logic [PH_W-1:0] high_len(input logic b);
    return b ? PH_W'(T1H_CYC - 1) : PH_W'(T0H_CYC - 1);
  endfunction

  function automatic logic [PH_W-1:0] low_len(input logic b);
    return b ? PH_W'(T1L_CYC - 1) : PH_W'(T0L_CYC - 1);
  endfunction

  assign phase_end   = (phase == '0);
  assign last_bit    = (bit_cnt == 5'd23);
  assign last_led    = (led_idx == cfg_max - CNT_W'(1));
  assign first_color = led_color('0, bus.seg_colors, bus.seg_limits, bus.on_count,
                                 bus.peak_en, bus.peak_pos, bus.peak_color);

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Reset asserts immediately but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  // Next-state decode; dropping enable aborts any frame without a done pulse.
  always_comb begin
    state_next = state;
    if (!bus.enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start || bus.auto_mode) state_next = LATCH;
        LATCH:   if (phase_end) state_next = (bus.max_count == '0) ? DONE : HIGH;
        HIGH:    if (phase_end) state_next = LOW;
        LOW:     if (phase_end) state_next = (last_bit && last_led) ? DONE : HIGH;
        DONE:    state_next = bus.auto_mode ? LATCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, phase/bit/LED counters and registered outputs.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      led_idx <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      dout_q <= bus.enable && (state == HIGH);
      done_q <= bus.enable && (state == DONE);
      busy_q <= bus.enable && ((state != IDLE) || (state_next != IDLE));
      case (state)
        LATCH: phase <= phase_end ? high_len(first_color[23]) : phase - PH_W'(1);
        HIGH:  phase <= phase_end ? low_len(shift[23]) : phase - PH_W'(1);
        LOW: begin
          if (!phase_end) begin
            phase <= phase - PH_W'(1);
          end else if (last_bit) begin
            bit_cnt <= '0;
            led_idx <= led_idx + CNT_W'(1);
            phase   <= high_len(next_color[23]);
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            phase   <= high_len(shift[22]);
          end
        end
        default: begin
          phase   <= PH_W'(RESET_CYC - 1);
          bit_cnt <= '0;
          led_idx <= '0;
        end
      endcase
    end
  end

  // Frame configuration capture, bit shifter and one-LED-ahead colour lookup.
  always_ff @(posedge clk) begin
    if (state == LATCH && phase_end) begin
      cfg_colors <= bus.seg_colors;
      cfg_limits <= bus.seg_limits;
      cfg_on     <= bus.on_count;
      cfg_max    <= bus.max_count;
      cfg_pk_en  <= bus.peak_en;
      cfg_pos    <= bus.peak_pos;
      cfg_pk_col <= bus.peak_color;
      shift      <= first_color;
    end else if (state == LOW && phase_end) begin
      shift <= last_bit ? next_color : {shift[22:0], 1'b0};
    end
    next_color <= led_color(led_idx + CNT_W'(1), cfg_colors, cfg_limits, cfg_on,
                            cfg_pk_en, cfg_pos, cfg_pk_col);
  end

endmodule

// File: tb/tb_ws2812b_bar_driver.sv
// Bench for ws2812b_bar_driver: decodes the serial waveform bit window by
// bit window and compares every LED word with a colour model of the bar.
`timescale 1ns/1ps
module tb_ws2812b_bar_driver;
  localparam int SEG_N = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ws2812b_bar_driver_if #(.SEG_N(SEG_N), .CNT_W(CNT_W)) bus ();

  ws2812b_bar_driver #(
    .CLK_PERIOD_NS(10), .SEG_N(SEG_N), .CNT_W(CNT_W),
    .T0H_NS(400), .T0L_NS(850), .T1H_NS(800), .T1L_NS(450), .RESET_NS(1000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] col[SEG_N];
  int          lim[SEG_N];
  int          on_cnt, max_cnt, pk_pos;
  bit          pk_en;
  logic [23:0] pk_col;
  logic [23:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg();
    for (int k = 0; k < SEG_N; k++) begin
      bus.seg_colors[k*24 +: 24]       = col[k];
      bus.seg_limits[k*CNT_W +: CNT_W] = CNT_W'(lim[k]);
    end
    bus.on_count   = CNT_W'(on_cnt);
    bus.max_count  = CNT_W'(max_cnt);
    bus.peak_en    = pk_en;
    bus.peak_pos   = CNT_W'(pk_pos);
    bus.peak_color = pk_col;
  endtask

  task automatic randomize_cfg(input int max_leds);
    for (int k = 0; k < SEG_N; k++) begin
      col[k] = 24'($urandom);
      lim[k] = $urandom_range(0, 4);
    end
    on_cnt  = $urandom_range(0, 4);
    max_cnt = $urandom_range(0, max_leds);
    pk_en   = 1'($urandom_range(0, 1));
    pk_pos  = $urandom_range(0, 3);
    pk_col  = 24'($urandom);
  endtask

  // Colour the bar should show at LED i under the current model config.
  function automatic logic [23:0] ref_color(input int i);
    if (pk_en && i == pk_pos && pk_pos < max_cnt) return pk_col;
    if (i >= on_cnt || i >= max_cnt) return 24'h0;
    for (int k = 0; k < SEG_N; k++)
      if (i < lim[k]) return col[k];
    return 24'h0;
  endfunction

  // Follows one frame from the accepting edge to the done sample. Each bit
  // must be exactly 125 cycles: 40 or 80 high, then low for the remainder.
  task automatic run_frame(input string tag, input bit pulse_start, input bit disturb);
    int          highs, bad, h;
    bit          in_low, ok;
    logic [23:0] got;
    exp_q.delete();
    for (int i = 0; i < max_cnt; i++) exp_q.push_back(ref_color(i));
    if (pulse_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_val({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
    end
    highs = 0;
    for (int s = 0; s < 100; s++) begin
      step();
      if (bus.dout) highs++;
    end
    check_val({tag, ".latch_low"}, 32'(highs), 32'd0);
    for (int l = 0; l < exp_q.size(); l++) begin
      got = '0;
      bad = 0;
      for (int b = 0; b < 24; b++) begin
        h = 0; in_low = 1'b0; ok = 1'b1;
        for (int s = 0; s < 125; s++) begin
          if (disturb && l == 0 && b == 0 && s == 0) begin
            randomize_cfg(2);
            drive_cfg();
            bus.start = 1'b1;
          end else if (disturb && l == 0 && b == 0 && s == 1) begin
            bus.start = 1'b0;
          end
          step();
          if (bus.dout) begin
            if (in_low) ok = 1'b0;
            else h++;
          end else begin
            in_low = 1'b1;
          end
        end
        if (!ok || (h != 40 && h != 80)) bad++;
        got = {got[22:0], (h == 80)};
      end
      check_val($sformatf("%s.led%0d.timing", tag, l), 32'(bad), 32'd0);
      check_val($sformatf("%s.led%0d.color", tag, l), 32'(got), 32'(exp_q[l]));
    end
    step();
    check_val({tag, ".done"}, 32'(bus.done), 32'd1);
    check_val({tag, ".done_dout"}, 32'(bus.dout), 32'd0);
    check_val({tag, ".done_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    step();
    check_val({tag, ".busy_drop"}, 32'(bus.busy), 32'd0);
    check_val({tag, ".done_drop"}, 32'(bus.done), 32'd0);
  endtask

  int cnt_done, cnt_dout, cnt_busy;

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.start = 1'b0; bus.auto_mode = 1'b0;
    for (int k = 0; k < SEG_N; k++) begin col[k] = '0; lim[k] = 0; end
    on_cnt = 0; max_cnt = 0; pk_en = 1'b0; pk_pos = 0; pk_col = '0;
    drive_cfg();
    repeat (3) step();
    check_val("rst.dout", 32'(bus.dout), 32'd0);
    check_val("rst.busy", 32'(bus.busy), 32'd0);
    check_val("rst.done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    bus.enable = 1'b1;
    step();
    check_val("idle.busy", 32'(bus.busy), 32'd0);

    // Single LED, one segment.
    col[0] = 24'hA50000; lim[0] = 1; on_cnt = 1; max_cnt = 1;
    drive_cfg();
    run_frame("single", 1'b1, 1'b0);
    expect_idle("single");

    // Three segments, partial fill, peak marker on the last LED.
    col[0] = 24'h111111; col[1] = 24'h222222; col[2] = 24'h333333;
    lim[0] = 2; lim[1] = 4; lim[2] = 6;
    on_cnt = 5; max_cnt = 8; pk_en = 1'b1; pk_pos = 7; pk_col = 24'hFFFFFF;
    drive_cfg();
    run_frame("bar8", 1'b1, 1'b0);
    expect_idle("bar8");

    // on_count beyond max_count, peak just past the end of the strip.
    on_cnt = 5; max_cnt = 2; pk_pos = 2;
    drive_cfg();
    run_frame("edge", 1'b1, 1'b0);
    expect_idle("edge");

    // Empty strip: latch period then done.
    max_cnt = 0;
    drive_cfg();
    run_frame("empty", 1'b1, 1'b0);
    expect_idle("empty");

    // Auto mode: back-to-back frames, then abort mid-bit.
    max_cnt = 2; pk_en = 1'b0;
    drive_cfg();
    bus.auto_mode = 1'b1;
    run_frame("auto1", 1'b1, 1'b0);
    run_frame("auto2", 1'b0, 1'b0);
    repeat (130) step();
    check_val("abort.dout_before", 32'(bus.dout), 32'd1);
    bus.enable = 1'b0;
    step();
    check_val("abort.dout", 32'(bus.dout), 32'd0);
    check_val("abort.busy", 32'(bus.busy), 32'd0);
    cnt_done = 0; cnt_dout = 0;
    for (int s = 0; s < 200; s++) begin
      step();
      if (bus.done) cnt_done++;
      if (bus.dout) cnt_dout++;
    end
    check_val("abort.no_done", 32'(cnt_done), 32'd0);
    check_val("abort.no_dout", 32'(cnt_dout), 32'd0);
    bus.auto_mode = 1'b0;
    bus.enable = 1'b1;

    // Asynchronous reset in the middle of a lit bit.
    max_cnt = 1; on_cnt = 1; lim[0] = 1; col[0] = 24'hFFFFFF;
    drive_cfg();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (110) step();
    check_val("arst.dout_before", 32'(bus.dout), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("arst.dout", 32'(bus.dout), 32'd0);
    check_val("arst.busy", 32'(bus.busy), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();

    // Config changes and a start pulse mid-frame only affect the next frame.
    run_frame("midchg", 1'b1, 1'b1);
    cnt_busy = 0;
    for (int s = 0; s < 150; s++) begin
      step();
      if (bus.busy) cnt_busy++;
    end
    check_val("midchg.no_requeue", 32'(cnt_busy), 32'd0);
    run_frame("newcfg", 1'b1, 1'b0);
    expect_idle("newcfg");

    // Random bars.
    for (int r = 0; r < 2; r++) begin
      randomize_cfg(2);
      drive_cfg();
      run_frame($sformatf("rand%0d", r), 1'b1, 1'b0);
      expect_idle($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
